// File: rtl/gnr_attractor_ctrl_if.sv
// Purpose : bundle of the controller's node-control lines and its result
//           channel, shared between the controller (master) and the
//           network nodes plus result consumer (slave).
// Signals :
//   reset_nos, init_state, start_s0, start_s1  controller -> nodes
//   s0_vec, s1_vec                             nodes -> controller
//   res_valid, res_init, res_steps,
//   res_period, res_timeout                    controller -> consumer
//   res_ready                                  consumer -> controller
interface gnr_attractor_ctrl_if #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16
);
  logic                 reset_nos;
  logic [NUM_NODES-1:0] init_state;
  logic                 start_s0;
  logic                 start_s1;
  logic [NUM_NODES-1:0] s0_vec;
  logic [NUM_NODES-1:0] s1_vec;
  logic                 res_valid;
  logic                 res_ready;
  logic [NUM_NODES-1:0] res_init;
  logic [CNT_W-1:0]     res_steps;
  logic [CNT_W-1:0]     res_period;
  logic                 res_timeout;

  modport master (
    output reset_nos, init_state, start_s0, start_s1,
    input  s0_vec, s1_vec,
    output res_valid, res_init, res_steps, res_period, res_timeout,
    input  res_ready
  );

  modport slave (
    input  reset_nos, init_state, start_s0, start_s1,
    output s0_vec, s1_vec,
    input  res_valid, res_init, res_steps, res_period, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Purpose : sequencer and tortoise/hare attractor detector for one
//           gene-regulatory-network instance. Sweeps every initial state,
//           measures transient step count and attractor period for each,
//           and hands one result per initial state to the consumer.
// Ports   :
//   clk    clock
//   rst    synchronous active-high reset
//   start  begin a sweep (only looked at in IDLE)
//   busy   high whenever the FSM is not in IDLE
//   done   one-cycle pulse after the last result is accepted
//   bus    node-control lines and result channel (master side)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | reset_nos pulse, nodes load init_state
// STEP  | hare steps; tortoise steps too except on the first step
// CMP   | compare s0/s1 after a step, check step limit
// PSTEP | hare steps alone around the attractor
// PCMP  | compare s0/s1 after a period step, check period limit
// OUT   | result held until the consumer accepts it
module gnr_attractor_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  gnr_attractor_ctrl_if.master bus
);

  localparam logic [NUM_NODES-1:0] LAST_INIT = '1;
  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_CMP, S_PSTEP, S_PCMP, S_OUT
  } state_t;

  state_t               r_state, w_next;
  logic [NUM_NODES-1:0] r_init_cnt;
  logic [CNT_W-1:0]     r_step_cnt;
  logic [CNT_W-1:0]     r_period_cnt;
  logic                 r_first;
  logic                 r_done;
  logic                 r_res_valid;
  logic [NUM_NODES-1:0] r_res_init;
  logic [CNT_W-1:0]     r_res_steps;
  logic [CNT_W-1:0]     r_res_period;
  logic                 r_res_timeout;

  logic w_match, w_hs, w_res_load, w_res_to;

  assign w_match = (bus.s0_vec == bus.s1_vec);
  assign w_hs    = (r_state == S_OUT) && r_res_valid && bus.res_ready;

  always_comb begin
    w_next     = r_state;
    w_res_load = 1'b0;
    w_res_to   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_STEP;
      S_STEP:  w_next = S_CMP;
      S_CMP: begin
        if (w_match) begin
          w_next = S_PSTEP;
        end else if (r_step_cnt == MAX_CNT) begin
          w_next     = S_OUT;
          w_res_load = 1'b1;
          w_res_to   = 1'b1;
        end else begin
          w_next = S_STEP;
        end
      end
      S_PSTEP: w_next = S_PCMP;
      S_PCMP: begin
        if (w_match) begin
          w_next     = S_OUT;
          w_res_load = 1'b1;
        end else if (r_period_cnt == MAX_CNT) begin
          w_next     = S_OUT;
          w_res_load = 1'b1;
          w_res_to   = 1'b1;
        end else begin
          w_next = S_PSTEP;
        end
      end
      S_OUT: begin
        if (w_hs) w_next = (r_init_cnt == LAST_INIT) ? S_IDLE : S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_init_cnt    <= '0;
      r_step_cnt    <= '0;
      r_period_cnt  <= '0;
      r_first       <= 1'b0;
      r_done        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_init    <= '0;
      r_res_steps   <= '0;
      r_res_period  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE:  if (start) r_init_cnt <= '0;
        S_LOAD: begin
          r_step_cnt <= '0;
          r_first    <= 1'b1;
        end
        S_STEP: begin
          r_step_cnt <= r_step_cnt + 1'b1;
          r_first    <= 1'b0;
        end
        S_CMP:   if (w_match) r_period_cnt <= '0;
        S_PSTEP: r_period_cnt <= r_period_cnt + 1'b1;
        S_OUT: begin
          if (w_hs) begin
            r_res_valid <= 1'b0;
            if (r_init_cnt == LAST_INIT) r_done <= 1'b1;
            else                         r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Result is captured on the transition into OUT and then frozen.
      if (w_res_load) begin
        r_res_valid   <= 1'b1;
        r_res_init    <= r_init_cnt;
        r_res_steps   <= r_step_cnt;
        r_res_period  <= w_res_to ? '0 : r_period_cnt;
        r_res_timeout <= w_res_to;
      end
    end
  end

  assign bus.reset_nos   = (r_state == S_LOAD);
  assign bus.init_state  = r_init_cnt;
  assign bus.start_s1    = (r_state == S_STEP) || (r_state == S_PSTEP);
  // The first step after a load advances the hare only.
  assign bus.start_s0    = (r_state == S_STEP) && !r_first;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_init    = r_res_init;
  assign bus.res_steps   = r_res_steps;
  assign bus.res_period  = r_res_period;
  assign bus.res_timeout = r_res_timeout;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Purpose : self-checking bench for gnr_attractor_ctrl. Two controllers
//           (long and very short step limit) drive behavioural 3-node
//           networks whose next-state function is a lookup table; results
//           are compared against a reference computed directly from
//           iterating that function.
module tb_gnr_attractor_ctrl;
  localparam int N  = 3;
  localparam int CW = 16;
  localparam int NS = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] f_tab [NS];

  logic          start [2];
  logic          ready [2];
  logic          busy  [2];
  logic          done  [2];
  logic          rn    [2];
  logic          ss0   [2];
  logic          ss1   [2];
  logic          rv    [2];
  logic          rto   [2];
  logic [N-1:0]  istate[2];
  logic [N-1:0]  rinit [2];
  logic [CW-1:0] rsteps[2];
  logic [CW-1:0] rper  [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit prev_rn [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MAXS = (g == 0) ? 1000 : 4;
    gnr_attractor_ctrl_if #(.NUM_NODES(N), .CNT_W(CW)) bus ();
    gnr_attractor_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start[g]),
      .busy (busy[g]),
      .done (done[g]),
      .bus  (bus)
    );

    // Behavioural nodes: s1 follows every step, s0 only every other step.
    logic [N-1:0] r_s0, r_s1;
    logic         r_pass;
    always @(posedge clk) begin
      if (bus.reset_nos) begin
        r_s0   <= bus.init_state;
        r_s1   <= bus.init_state;
        r_pass <= 1'b1;
      end else begin
        if (bus.start_s1) r_s1 <= f_tab[r_s1];
        if (bus.start_s0) begin
          if (r_pass) r_s0 <= f_tab[r_s0];
          r_pass <= ~r_pass;
        end
      end
    end
    assign bus.s0_vec    = r_s0;
    assign bus.s1_vec    = r_s1;
    assign bus.res_ready = ready[g];
    assign rn[g]     = bus.reset_nos;
    assign ss0[g]    = bus.start_s0;
    assign ss1[g]    = bus.start_s1;
    assign istate[g] = bus.init_state;
    assign rv[g]     = bus.res_valid;
    assign rinit[g]  = bus.res_init;
    assign rsteps[g] = bus.res_steps;
    assign rper[g]   = bus.res_period;
    assign rto[g]    = bus.res_timeout;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] iter(input logic [N-1:0] x, input int n);
    logic [N-1:0] v = x;
    for (int i = 0; i < n; i++) v = f_tab[v];
    return v;
  endfunction

  // Reference: hare at f^k(x), tortoise at f^(k/2)(x); first k where they
  // meet, then hare-only steps back to the meeting point.
  task automatic model(input int x, input int maxs,
                       output int steps, output int period, output bit to);
    logic [N-1:0] meet;
    to = 1'b1; steps = maxs; period = 0;
    for (int k = 1; k <= maxs; k++) begin
      if (iter(N'(x), k) == iter(N'(x), k / 2)) begin
        steps = k; to = 1'b0; break;
      end
    end
    if (!to) begin
      meet = iter(N'(x), steps);
      to = 1'b1;
      for (int p = 1; p <= maxs; p++) begin
        if (iter(meet, p) == meet) begin
          period = p; to = 1'b0; break;
        end
      end
      if (to) period = 0;
    end
  endtask

  // Protocol monitor: first step after a load is hare-only; no node
  // control pulses while a result is pending.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        if (prev_rn[g]) begin
          check_val("first_step_s1", int'(ss1[g]), 1);
          check_val("first_step_s0", int'(ss0[g]), 0);
        end
        if (rv[g]) check_val("out_quiet", int'(rn[g] | ss0[g] | ss1[g]), 0);
        prev_rn[g] = rn[g];
      end
    end
  end

  task automatic check_idle_outputs(input int g, input string tag);
    check_val({tag, "_busy"}, int'(busy[g]), 0);
    check_val({tag, "_done"}, int'(done[g]), 0);
    check_val({tag, "_ctrl"}, int'({rn[g], ss0[g], ss1[g]}), 0);
    check_val({tag, "_init_state"}, int'(istate[g]), 0);
    check_val({tag, "_res_valid"}, int'(rv[g]), 0);
    check_val({tag, "_res"}, int'(rinit[g]) + int'(rsteps[g]) + int'(rper[g]) + int'(rto[g]), 0);
  endtask

  task automatic run_sweep(input int g, input int maxs, input bit bp);
    int steps, period, cnt, d;
    bit to;
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    check_val("busy_after_start", int'(busy[g]), 1);
    for (int x = 0; x < NS; x++) begin
      model(x, maxs, steps, period, to);
      if (x == 0) begin
        start[g] = 1'b1;                 // must be ignored while busy
        @(negedge clk); start[g] = 1'b0;
      end
      cnt = 0;
      while (!rv[g] && cnt < 5000) begin
        @(negedge clk); cnt++;
      end
      if (!rv[g]) begin
        check_val("wait_res_valid", 0, 1);
        return;
      end
      check_val("res_init", int'(rinit[g]), x);
      check_val("res_steps", int'(rsteps[g]), steps);
      check_val("res_period", int'(rper[g]), period);
      check_val("res_timeout", int'(rto[g]), int'(to));
      d = (bp && x == 2) ? 10 : $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        check_val("hold_valid", int'(rv[g]), 1);
        check_val("hold_init", int'(rinit[g]), x);
        check_val("hold_steps", int'(rsteps[g]), steps);
        check_val("hold_period", int'(rper[g]), period);
      end
      ready[g] = 1'b1;
      @(negedge clk); ready[g] = 1'b0;
      check_val("valid_drop", int'(rv[g]), 0);
      if (x == NS - 1) begin
        check_val("done_pulse", int'(done[g]), 1);
        check_val("busy_end", int'(busy[g]), 0);
        @(negedge clk);
        check_val("done_clear", int'(done[g]), 0);
      end else begin
        check_val("next_load", int'(rn[g]), 1);
        check_val("next_init", int'(istate[g]), x + 1);
        check_val("done_mid", int'(done[g]), 0);
      end
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < NS; i++) f_tab[i] = N'(i);
  endtask

  task automatic set_rotate();
    logic [N-1:0] v;
    for (int i = 0; i < NS; i++) begin
      v = N'(i);
      f_tab[i] = {v[N-2:0], v[N-1]};
    end
  endtask

  task automatic reset_in_pstep();
    int cnt = 0;
    bit last_rn = 1'b0;
    bit found = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    while (!found && cnt < 2000) begin
      if (ss1[0] && !ss0[0] && !last_rn) found = 1'b1;
      else begin
        last_rn = rn[0];
        @(negedge clk); cnt++;
      end
    end
    check_val("pstep_found", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(0, "mid_reset");
    repeat (3) @(negedge clk);
    check_val("no_done_after_abort", int'(done[0]), 0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; ready[g] = 1'b0; prev_rn[g] = 1'b0;
    end
    set_identity();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");

    run_sweep(0, 1000, 1'b0);
    set_rotate();
    run_sweep(0, 1000, 1'b1);
    run_sweep(1, 4, 1'b0);
    reset_in_pstep();
    run_sweep(0, 1000, 1'b0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NS; i++) f_tab[i] = N'($urandom_range(0, NS - 1));
      run_sweep(0, 1000, r[0]);
      run_sweep(1, 4, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
